// File: rtl/pipe_sched.sv
// Pipeline sequencer for the 8-bit core: registered stage enables, en/ready handoff,
// RAW scoreboard between decode and execute, and taken-branch flush from execute.
module pipe_sched #(
    parameter int REG_CNT        = 16,
    parameter int REG_ADDR_WIDTH = $clog2(REG_CNT),
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_busy,
    input  logic                      fetch_ready,
    output logic                      fetch_en,
    input  logic                      decode_ready,
    input  logic [REG_ADDR_WIDTH-1:0] decode_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] decode_rs2,
    input  logic                      decode_rs1_used,
    input  logic                      decode_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0] decode_rd,
    input  logic                      decode_rd_we,
    output logic                      decode_en,
    input  logic                      exec_ready,
    input  logic                      exec_flush,
    output logic                      exec_en,
    input  logic                      wb_ready,
    output logic                      wb_en,
    output logic                      capture_fd,
    output logic                      capture_de,
    output logic                      capture_ew,
    output logic                      pc_advance,
    output logic                      pc_load,
    output logic [CNT_WIDTH-1:0]      hazard_stalls
);

    logic [REG_CNT-1:0]        sb;
    logic [REG_CNT-1:0]        sb_set;
    logic [REG_CNT-1:0]        sb_clr;
    logic [REG_CNT-1:0]        sb_nxt;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic [REG_ADDR_WIDTH-1:0] wb_rd;
    logic                      ex_vld;
    logic                      wb_vld;

    logic ew_go;
    logic flush;
    logic fd_go;
    logic de_go;
    logic wb_done;
    logic fetch_go;
    logic rs1_hit;
    logic rs2_hit;
    logic hazard;
    logic rd_vld;
    logic stall_inc;

    always_comb begin
        ew_go     = exec_en & exec_ready & ~wb_en;
        flush     = ew_go & exec_flush;
        rs1_hit   = decode_rs1_used & (decode_rs1 != '0) & sb[decode_rs1];
        rs2_hit   = decode_rs2_used & (decode_rs2 != '0) & sb[decode_rs2];
        hazard    = rs1_hit | rs2_hit;
        fd_go     = fetch_en & fetch_ready & ~decode_en & ~flush;
        de_go     = decode_en & decode_ready & ~exec_en & ~hazard & ~flush;
        stall_inc = decode_en & decode_ready & ~exec_en & hazard & ~flush;
        wb_done   = wb_en & wb_ready;
        fetch_go  = ~fetch_en & ~fetch_busy & ~flush;
        rd_vld    = decode_rd_we & (decode_rd != '0);

        // Clears are applied first so a same-cycle set of the same index wins.
        sb_clr = '0;
        sb_set = '0;
        if (wb_done & wb_vld) sb_clr[wb_rd] = 1'b1;
        if (flush & ex_vld)   sb_clr[ex_rd] = 1'b1;
        if (de_go & rd_vld)   sb_set[decode_rd] = 1'b1;
        sb_nxt = (sb & ~sb_clr) | sb_set;
    end

    assign capture_fd = fd_go;
    assign capture_de = de_go;
    assign capture_ew = ew_go;
    assign pc_advance = fd_go;
    assign pc_load    = flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_en      <= 1'b0;
            decode_en     <= 1'b0;
            exec_en       <= 1'b0;
            wb_en         <= 1'b0;
            sb            <= '0;
            ex_rd         <= '0;
            wb_rd         <= '0;
            ex_vld        <= 1'b0;
            wb_vld        <= 1'b0;
            hazard_stalls <= '0;
        end else begin
            if (flush)         fetch_en <= 1'b0;
            else if (fd_go)    fetch_en <= 1'b0;
            else if (fetch_go) fetch_en <= 1'b1;

            if (flush)      decode_en <= 1'b0;
            else if (fd_go) decode_en <= 1'b1;
            else if (de_go) decode_en <= 1'b0;

            if (de_go) begin
                exec_en <= 1'b1;
                ex_rd   <= decode_rd;
                ex_vld  <= rd_vld;
            end else if (ew_go) begin
                exec_en <= 1'b0;
            end

            // A flushing instruction never reaches writeback.
            if (ew_go & ~exec_flush) begin
                wb_en  <= 1'b1;
                wb_rd  <= ex_rd;
                wb_vld <= ex_vld;
            end else if (wb_done) begin
                wb_en <= 1'b0;
            end

            sb <= sb_nxt;

            if (stall_inc && (hazard_stalls != '1))
                hazard_stalls <= hazard_stalls + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_sched.sv
// Bench for pipe_sched: models the stage datapath with per-stage ready latencies and
// checks writeback order against a queue of fetched instructions.
module tb_pipe_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_busy, fetch_ready, fetch_en;
    logic        decode_ready, decode_en;
    logic [3:0]  decode_rs1, decode_rs2, decode_rd;
    logic        decode_rs1_used, decode_rs2_used, decode_rd_we;
    logic        exec_ready, exec_flush, exec_en;
    logic        wb_ready, wb_en;
    logic        capture_fd, capture_de, capture_ew, pc_advance, pc_load;
    logic [15:0] hazard_stalls;

    pipe_sched #(.REG_CNT(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .fetch_busy(fetch_busy), .fetch_ready(fetch_ready), .fetch_en(fetch_en),
        .decode_ready(decode_ready), .decode_rs1(decode_rs1), .decode_rs2(decode_rs2),
        .decode_rs1_used(decode_rs1_used), .decode_rs2_used(decode_rs2_used),
        .decode_rd(decode_rd), .decode_rd_we(decode_rd_we), .decode_en(decode_en),
        .exec_ready(exec_ready), .exec_flush(exec_flush), .exec_en(exec_en),
        .wb_ready(wb_ready), .wb_en(wb_en),
        .capture_fd(capture_fd), .capture_de(capture_de), .capture_ew(capture_ew),
        .pc_advance(pc_advance), .pc_load(pc_load), .hazard_stalls(hazard_stalls)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [3:0] p_rd[16], p_rs1[16], p_rs2[16];
    logic       p_we[16], p_u1[16], p_u2[16], p_fl[16];
    int n_prog, fidx, d_inst, e_inst, w_inst;
    int lat_f = 1, lat_d = 1, lat_e = 1, lat_w = 1;
    int age_f, age_d, age_e, age_w;
    int q[$];
    int cyc, n_pa, n_ew, n_both, n_sb0, n_done, n_blk;
    int wb_cyc[16], de_cyc[16];
    logic [15:0] sb_or;
    logic l_fd, l_de, l_ew, l_pa, l_pl;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input int i, input int rd, input int we, input int rs1,
                             input int u1, input int rs2, input int u2, input int fl);
        p_rd[i]  = rd[3:0];
        p_we[i]  = we[0];
        p_rs1[i] = rs1[3:0];
        p_u1[i]  = u1[0];
        p_rs2[i] = rs2[3:0];
        p_u2[i]  = u2[0];
        p_fl[i]  = fl[0];
    endtask

    task automatic drive();
        fetch_ready     = fetch_en && (age_f >= lat_f) && (fidx < n_prog);
        decode_ready    = decode_en && (age_d >= lat_d);
        exec_ready      = exec_en && (age_e >= lat_e);
        wb_ready        = wb_en && (age_w >= lat_w);
        exec_flush      = p_fl[e_inst];
        decode_rs1      = p_rs1[d_inst];
        decode_rs2      = p_rs2[d_inst];
        decode_rs1_used = p_u1[d_inst];
        decode_rs2_used = p_u2[d_inst];
        decode_rd       = p_rd[d_inst];
        decode_rd_we    = p_we[d_inst];
    endtask

    task automatic cycle();
        @(negedge clk);
        l_fd = capture_fd;
        l_de = capture_de;
        l_ew = capture_ew;
        l_pa = pc_advance;
        l_pl = pc_load;
        n_pa += int'(pc_advance);
        n_ew += int'(capture_ew);
        if (pc_advance && pc_load) n_both++;
        if (dut.sb[0]) n_sb0++;
        sb_or |= dut.sb;
        if (decode_en && decode_ready && !exec_en && !capture_de && !pc_load) n_blk++;
        if (l_de) de_cyc[d_inst] = cyc;
        if (wb_en && wb_ready) begin
            n_done++;
            wb_cyc[w_inst] = cyc;
            if (q.size() == 0) chk("wb_order", w_inst, -1);
            else chk("wb_order", w_inst, q.pop_front());
        end
        @(posedge clk);
        #1;
        cyc++;
        if (l_ew && !l_pl) w_inst = e_inst;
        if (l_pl) begin
            // squash the flushing instruction and everything younger, then refetch after it
            while (q.size() > 0 && q[$] >= e_inst) void'(q.pop_back());
            fidx = e_inst + 1;
        end
        if (l_de) e_inst = d_inst;
        if (l_fd) begin
            d_inst = fidx;
            q.push_back(fidx);
            fidx++;
        end
        age_f = fetch_en  ? age_f + 1 : 0;
        age_d = decode_en ? age_d + 1 : 0;
        age_e = exec_en   ? age_e + 1 : 0;
        age_w = wb_en     ? age_w + 1 : 0;
        drive();
    endtask

    task automatic run_until_idle(input string tag, input int max);
        int idle = 0;
        for (int i = 0; i < max && idle == 0; i++) begin
            cycle();
            if (fidx >= n_prog && q.size() == 0 && !decode_en && !exec_en && !wb_en) idle = 1;
        end
        chk(tag, idle, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st0, b0, d0, found, held;
        rst = 1'b1;
        fetch_busy = 1'b0;
        n_prog = 0; fidx = 0; d_inst = 0; e_inst = 0; w_inst = 0;
        age_f = 0; age_d = 0; age_e = 0; age_w = 0;
        cyc = 0; n_pa = 0; n_ew = 0; n_both = 0; n_sb0 = 0; n_done = 0; n_blk = 0;
        sb_or = '0;
        for (int i = 0; i < 16; i++) begin
            set_instr(i, 0, 0, 0, 0, 0, 0, 0);
            wb_cyc[i] = 0;
            de_cyc[i] = 0;
        end
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // independent stream, sources read x0
        set_instr(0, 1, 1, 0, 1, 0, 0, 0);
        set_instr(1, 2, 1, 0, 1, 0, 1, 0);
        set_instr(2, 3, 1, 0, 0, 0, 1, 0);
        n_prog = 3; fidx = 0;
        drive();
        chk("rst_fetch_en", int'(fetch_en), 0);
        chk("rst_other_en", int'({decode_en, exec_en, wb_en}), 0);
        chk("rst_pulses", int'({capture_fd, capture_de, capture_ew, pc_advance, pc_load}), 0);
        chk("rst_sb", int'(dut.sb), 0);
        chk("rst_stalls", int'(hazard_stalls), 0);

        cycle();
        chk("fetch_start", int'(fetch_en), 1);
        cycle();
        chk("fd_capture", int'(l_fd), 1);
        chk("fd_pc_advance", int'(l_pa), 1);
        chk("fd_decode_en", int'(decode_en), 1);
        chk("fd_fetch_en", int'(fetch_en), 0);
        cycle();
        chk("pc_advance_once", int'(l_pa), 0);
        run_until_idle("indep_idle", 100);
        chk("indep_pc_advance", n_pa, 3);
        chk("indep_capture_ew", n_ew, 3);
        chk("indep_done", n_done, 3);
        chk("indep_stalls", int'(hazard_stalls), 0);

        // RAW: A writes x5, B reads x5; writeback takes lat_w cycles
        lat_w = 3;
        st0 = int'(hazard_stalls);
        b0 = n_blk;
        set_instr(0, 5, 1, 0, 0, 0, 0, 0);
        set_instr(1, 6, 1, 5, 1, 0, 0, 0);
        n_prog = 2; fidx = 0;
        drive();
        run_until_idle("raw_idle", 100);
        chk("raw_de_after_clear", de_cyc[1] - wb_cyc[0], 1);
        chk("raw_stalls", int'(hazard_stalls) - st0, lat_w);
        chk("raw_blocked", n_blk - b0, lat_w);

        // x0 destination followed by x0 reads
        lat_w = 1;
        st0 = int'(hazard_stalls);
        b0 = n_blk;
        d0 = n_done;
        sb_or = '0;
        set_instr(0, 0, 1, 0, 0, 0, 0, 0);
        set_instr(1, 0, 1, 0, 1, 0, 1, 0);
        n_prog = 2; fidx = 0;
        drive();
        run_until_idle("x0_idle", 100);
        chk("x0_stalls", int'(hazard_stalls) - st0, 0);
        chk("x0_blocked", n_blk - b0, 0);
        chk("x0_sb", int'(sb_or), 0);
        chk("x0_done", n_done - d0, 2);

        // flush while fetch and decode are both ready
        lat_e = 3;
        d0 = n_done;
        set_instr(0, 3, 1, 0, 0, 0, 0, 1);
        set_instr(1, 4, 1, 0, 0, 0, 0, 0);
        set_instr(2, 6, 1, 0, 0, 0, 0, 0);
        n_prog = 3; fidx = 0;
        drive();
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            cycle();
            if (l_pl) found = 1;
        end
        chk("flush_seen", found, 1);
        chk("flush_pc_advance", int'(l_pa), 0);
        chk("flush_capture_fd", int'(l_fd), 0);
        chk("flush_capture_de", int'(l_de), 0);
        chk("flush_enables", int'({fetch_en, decode_en, exec_en, wb_en}), 0);
        chk("flush_sb", int'(dut.sb), 0);
        fetch_busy = 1'b1;
        held = 0;
        repeat (3) begin
            cycle();
            held += int'(fetch_en);
        end
        chk("flush_fetch_hold", held, 0);
        fetch_busy = 1'b0;
        cycle();
        chk("fetch_restart", int'(fetch_en), 1);
        lat_e = 1;
        run_until_idle("flush_idle", 100);
        chk("flush_done", n_done - d0, 2);

        // reset with all four stages busy
        lat_w = 1000;
        set_instr(0, 2, 1, 0, 0, 0, 0, 0);
        set_instr(1, 5, 1, 0, 0, 0, 0, 0);
        set_instr(2, 7, 1, 0, 0, 0, 0, 0);
        set_instr(3, 8, 1, 0, 0, 0, 0, 0);
        n_prog = 4; fidx = 0;
        drive();
        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            cycle();
            if (fetch_en && decode_en && exec_en && wb_en) found = 1;
        end
        chk("busy_all", found, 1);
        chk("busy_sb", int'(dut.sb), 'h24);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive();
        chk("midrst_enables", int'({fetch_en, decode_en, exec_en, wb_en}), 0);
        chk("midrst_sb", int'(dut.sb), 0);
        chk("midrst_stalls", int'(hazard_stalls), 0);
        @(negedge clk);
        chk("midrst_pulses", int'({capture_fd, capture_de, capture_ew, pc_advance, pc_load}), 0);

        chk("pc_advance_load_excl", n_both, 0);
        chk("sb_x0_never_set", n_sb0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_sched.md
Name: pipe_sched

Overview:
Registered pipeline sequencer for the 8-bit core. It owns the enable lines of the fetch, decode, execute and writeback stages and moves an instruction between stages using each stage's en/ready handshake. A register scoreboard enforces read-after-write interlocks between decode and execute. Taken-branch flushes from execute clear the pipeline and load the PC. It replaces the combinational stage-start logic in the core top level.

Parameters:
REG_CNT, 16, number of architectural registers; x0 is never tracked.
REG_ADDR_WIDTH, $clog2(REG_CNT), register index width.
CNT_WIDTH, 16, width of the hazard-stall performance counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_busy  in  1  fetch unit still has a memory read outstanding
fetch_ready  in  1  fetch has produced an instruction; valid only while fetch_en=1
fetch_en  out  1  fetch stage enable
decode_ready  in  1  decode outputs valid; valid only while decode_en=1
decode_rs1  in  REG_ADDR_WIDTH  source register 1 index
decode_rs2  in  REG_ADDR_WIDTH  source register 2 index
decode_rs1_used  in  1  instruction reads rs1
decode_rs2_used  in  1  instruction reads rs2
decode_rd  in  REG_ADDR_WIDTH  destination register index
decode_rd_we  in  1  instruction writes rd
decode_en  out  1  decode stage enable
exec_ready  in  1  execute result valid; valid only while exec_en=1
exec_flush  in  1  taken control transfer; sampled only when exec_en & exec_ready
exec_en  out  1  execute stage enable
wb_ready  in  1  writeback done; valid only while wb_en=1
wb_en  out  1  writeback stage enable
capture_fd  out  1  pulse: datapath latches fetch outputs into decode inputs
capture_de  out  1  pulse: datapath latches decode outputs and register-file operands into execute
capture_ew  out  1  pulse: datapath latches the execute result into writeback
pc_advance  out  1  pulse: PC += 1
pc_load  out  1  pulse: PC <= execute pc_out
hazard_stalls  out  CNT_WIDTH  count of cycles in which decode→exec was blocked only by a hazard

Behaviour:
- Reset (rst=1 at a clk edge): all enables 0, all pulses 0, scoreboard 0, internal exec/wb rd trackers invalid, hazard_stalls 0. Reset mid-operation discards in-flight work immediately.
- All enables are registered. Transfer conditions are evaluated on registered enables, and an enable changes on the edge after its condition holds. Pulses are combinational, asserted in the same cycle as the transfer condition.
- Fetch start: fetch_en=0 & ~fetch_busy & no flush this cycle → fetch_en<=1.
- F→D: fetch_en & fetch_ready & decode_en=0 & no flush → capture_fd=1, pc_advance=1, fetch_en<=0, decode_en<=1.
- Hazard: (decode_rs1_used & rs1≠0 & sb[rs1]) | (decode_rs2_used & rs2≠0 & sb[rs2]), using the registered scoreboard. There is no bypass from a same-cycle writeback.
- D→E: decode_en & decode_ready & exec_en=0 & ~hazard & no flush → capture_de=1, decode_en<=0, exec_en<=1. Latch exec tracker = (decode_rd, decode_rd_we & rd≠0). If the tracker is valid, set sb[rd].
- E→W: exec_en & exec_ready & wb_en=0 → capture_ew=1, exec_en<=0.
  - If exec_flush=0: wb_en<=1, and the wb tracker takes the exec tracker.
  - If exec_flush=1 (flush): pc_load=1, wb_en stays 0, fetch_en<=0, decode_en<=0, and sb[exec rd] is cleared. Writeback of the flushing instruction is dropped.
- W done: wb_en & wb_ready → wb_en<=0, clear sb[wb rd] if the wb tracker is valid.
- Flush priority: in a flush cycle, F→D and D→E are suppressed (no pc_advance, no capture_fd/de, no scoreboard set). Fetch restarts only once fetch_busy=0.
- Same-cycle scoreboard set and clear of the same index: set wins.
- Transfers never chain within one cycle. A slot freed this cycle accepts the next instruction on the following cycle, giving a one-bubble handoff.
- hazard_stalls increments when decode_en & decode_ready & exec_en=0 & hazard & no flush. It saturates at all-ones.
- At most one of pc_advance and pc_load is high in any cycle.

Test Plan:
- Reset, then fetch_busy=0 → fetch_en=1 on the 1st edge after rst falls. Then fetch_ready=1 → capture_fd=1 and pc_advance=1 for exactly 1 cycle; decode_en=1 and fetch_en=0 on the next edge.
- Independent stream (rd=1,2,3; sources x0): the three instructions reach wb_en in order; hazard_stalls stays 0; each of pc_advance and capture_ew pulses exactly 3 times.
- RAW hazard: instr A writes x5 and instr B reads rs1=x5. B holds decode_en=1 with no capture_de until A's wb_ready cycle has passed; capture_de for B comes the cycle after sb[5] clears. hazard_stalls equals the number of blocked cycles.
- x0 destination (rd=0, rd_we=1) followed by a read of x0 → no stall; sb stays 0.
- Flush: exec_flush=1 with exec_ready while fetch_ready and decode_ready are also high → pc_load=1, pc_advance=0, capture_fd=0; next cycle fetch_en=0, decode_en=0, wb_en=0, sb[rd] cleared. Fetch restarts once fetch_busy=0.
- Assert rst with all four stages busy and sb=0x0024 → the next cycle shows all enables 0, sb=0, hazard_stalls=0.
